// File: rtl/tmds_decoder_if.sv
// rtl/tmds_decoder_if.sv - raw symbol input and decoded outputs of one TMDS channel
interface tmds_decoder_if;
  logic [9:0] isymbol;
  logic       obitslip;
  logic       olocked;
  logic [7:0] odata;
  logic       oc0;
  logic       oc1;
  logic       oDE;
  logic       olosspulse;

  modport master (
    output isymbol,
    input  obitslip, olocked, odata, oc0, oc1, oDE, olosspulse
  );

  modport slave (
    input  isymbol,
    output obitslip, olocked, odata, oc0, oc1, oDE, olosspulse
  );
endinterface

// File: rtl/tmds_decoder.sv
// rtl/tmds_decoder.sv - TMDS symbol decoder with control-token word alignment
// Searches for a run of control tokens, bitslips on timeout, drops lock on token starvation.
module tmds_decoder #(
  parameter int CTRL_RUN       = 16,
  parameter int SEARCH_TIMEOUT = 2048,
  parameter int SLIP_WAIT      = 8,
  parameter int LOSS_TIMEOUT   = 4096
) (
  input  logic          inclk,
  input  logic          ireset,
  tmds_decoder_if.slave tmds
);

  localparam int RUN_W  = $clog2(CTRL_RUN + 1);
  localparam int TO_W   = $clog2(SEARCH_TIMEOUT + 1);
  localparam int SLIP_W = $clog2(SLIP_WAIT + 1);
  localparam int WD_W   = $clog2(LOSS_TIMEOUT + 1);

  localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(CTRL_RUN);
  localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(SEARCH_TIMEOUT - 1);
  localparam logic [SLIP_W-1:0] SLIP_MAX = SLIP_W'(SLIP_WAIT - 1);
  localparam logic [WD_W-1:0]   WD_MAX   = WD_W'(LOSS_TIMEOUT - 1);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SLIP   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [9:0]        sym_q;
  logic [RUN_W-1:0]  run_q;
  logic [RUN_W-1:0]  run_d;
  logic [TO_W-1:0]   to_q;
  logic [TO_W-1:0]   to_d;
  logic [SLIP_W-1:0] slip_q;
  logic [SLIP_W-1:0] slip_d;
  logic [WD_W-1:0]   wd_q;
  logic [WD_W-1:0]   wd_d;

  logic              is_ctrl;
  logic [1:0]        ctrl_bits;
  logic [7:0]        d_inv;
  logic [7:0]        decoded;

  logic              bitslip_q;
  logic              locked_q;
  logic              loss_q;
  logic              de_q;
  logic [7:0]        data_q;
  logic [1:0]        ctrl_q;

  always_comb begin
    is_ctrl   = 1'b1;
    ctrl_bits = 2'b00;
    case (sym_q)
      10'h354: ctrl_bits = 2'b00;
      10'h0AB: ctrl_bits = 2'b01;
      10'h154: ctrl_bits = 2'b10;
      10'h2AB: ctrl_bits = 2'b11;
      default: is_ctrl   = 1'b0;
    endcase
  end

  // Bit 8 selects XOR or XNOR chaining; bit 9 marks an inverted payload.
  always_comb begin
    d_inv      = sym_q[9] ? ~sym_q[7:0] : sym_q[7:0];
    decoded    = 8'h00;
    decoded[0] = d_inv[0];
    for (int i = 1; i < 8; i++) begin
      decoded[i] = sym_q[8] ? (d_inv[i] ^ d_inv[i-1]) : ~(d_inv[i] ^ d_inv[i-1]);
    end
  end

  always_ff @(posedge inclk) begin
    if (ireset) begin
      state_q <= SEARCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    to_d    = to_q;
    slip_d  = slip_q;
    wd_d    = wd_q;
    case (state_q)
      SEARCH: begin
        run_d = is_ctrl ? ((run_q == RUN_MAX) ? run_q : run_q + 1'b1) : '0;
        to_d  = (to_q == TO_MAX) ? to_q : to_q + 1'b1;
        // A completed run takes priority over a timeout on the same edge.
        if (run_q == RUN_MAX) begin
          state_d = LOCKED;
          run_d   = '0;
          to_d    = '0;
          wd_d    = '0;
        end else if (to_q == TO_MAX) begin
          state_d = SLIP;
          run_d   = '0;
          to_d    = '0;
          slip_d  = '0;
        end
      end
      SLIP: begin
        if (slip_q == SLIP_MAX) begin
          state_d = SEARCH;
          run_d   = '0;
          to_d    = '0;
        end else begin
          slip_d = slip_q + 1'b1;
        end
      end
      LOCKED: begin
        if (is_ctrl) begin
          wd_d = '0;
        end else if (wd_q == WD_MAX) begin
          state_d = SEARCH;
          run_d   = '0;
          to_d    = '0;
          wd_d    = '0;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: begin
        state_d = SEARCH;
        run_d   = '0;
        to_d    = '0;
        slip_d  = '0;
        wd_d    = '0;
      end
    endcase
  end

  // Outputs are gated by the next state so they always agree with olocked.
  always_ff @(posedge inclk) begin
    if (ireset) begin
      sym_q     <= '0;
      run_q     <= '0;
      to_q      <= '0;
      slip_q    <= '0;
      wd_q      <= '0;
      bitslip_q <= 1'b0;
      locked_q  <= 1'b0;
      loss_q    <= 1'b0;
      de_q      <= 1'b0;
      data_q    <= 8'h00;
      ctrl_q    <= 2'b00;
    end else begin
      sym_q     <= tmds.isymbol;
      run_q     <= run_d;
      to_q      <= to_d;
      slip_q    <= slip_d;
      wd_q      <= wd_d;
      bitslip_q <= (state_q == SEARCH) && (state_d == SLIP);
      loss_q    <= (state_q == LOCKED) && (state_d == SEARCH);
      locked_q  <= (state_d == LOCKED);
      if (state_d == LOCKED) begin
        if (is_ctrl) begin
          de_q   <= 1'b0;
          data_q <= 8'h00;
          ctrl_q <= ctrl_bits;
        end else begin
          de_q   <= 1'b1;
          data_q <= decoded;
        end
      end else begin
        de_q   <= 1'b0;
        data_q <= 8'h00;
        ctrl_q <= 2'b00;
      end
    end
  end

  assign tmds.obitslip   = bitslip_q;
  assign tmds.olocked    = locked_q;
  assign tmds.olosspulse = loss_q;
  assign tmds.oDE        = de_q;
  assign tmds.odata      = data_q;
  assign tmds.oc1        = ctrl_q[1];
  assign tmds.oc0        = ctrl_q[0];

endmodule

// File: tb/tb_tmds_decoder.sv
// tb/tb_tmds_decoder.sv - directed bench with a cycle model of lock, slip, loss and decode
`timescale 1ns/1ps
module tb_tmds_decoder;

  localparam int CTRL_RUN       = 16;
  localparam int SEARCH_TIMEOUT = 2048;
  localparam int SLIP_WAIT      = 8;
  localparam int LOSS_TIMEOUT   = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  tmds_decoder_if bus ();

  always #5 clk = ~clk;

  tmds_decoder #(
    .CTRL_RUN       (CTRL_RUN),
    .SEARCH_TIMEOUT (SEARCH_TIMEOUT),
    .SLIP_WAIT      (SLIP_WAIT),
    .LOSS_TIMEOUT   (LOSS_TIMEOUT)
  ) dut (
    .inclk  (clk),
    .ireset (rst),
    .tmds   (bus)
  );

  // Model: tracks symbols seen, run length, search age, slip settle time, token starvation.
  bit         m_valid = 1'b0;
  logic [9:0] m_sym;
  bit         m_locked;
  int         m_slip_left, m_age, m_run, m_quiet;
  logic       e_slip, e_lock, e_loss, e_de;
  logic [1:0] e_c;
  logic [7:0] e_data;

  function automatic int token_code(input logic [9:0] s);
    case (s)
      10'h354: return 0;
      10'h0AB: return 1;
      10'h154: return 2;
      10'h2AB: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [7:0] tmds_byte(input logic [9:0] s);
    logic [7:0] x;
    logic [7:0] r;
    logic       t;
    x    = s[9] ? ~s[7:0] : s[7:0];
    r    = 8'h00;
    r[0] = x[0];
    for (int i = 1; i < 8; i++) begin
      t    = x[i] ^ x[i-1];
      r[i] = s[8] ? t : ~t;
    end
    return r;
  endfunction

  task automatic model_step(input logic r, input logic [9:0] sym);
    int tok;
    if (r) begin
      m_valid = 1'b1; m_sym = 10'h000; m_locked = 1'b0;
      m_slip_left = 0; m_age = 0; m_run = 0; m_quiet = 0;
      e_slip = 1'b0; e_lock = 1'b0; e_loss = 1'b0; e_de = 1'b0; e_c = 2'b00; e_data = 8'h00;
      return;
    end
    tok    = token_code(m_sym);
    e_slip = 1'b0;
    e_loss = 1'b0;
    if (m_slip_left > 0) begin
      m_slip_left--;
      if (m_slip_left == 0) begin m_age = 0; m_run = 0; end
    end else if (m_locked) begin
      if (tok >= 0) m_quiet = 0;
      else begin
        m_quiet++;
        if (m_quiet == LOSS_TIMEOUT) begin
          m_locked = 1'b0; e_loss = 1'b1; m_age = 0; m_run = 0; m_quiet = 0;
        end
      end
    end else if (m_run >= CTRL_RUN) begin
      m_locked = 1'b1; m_quiet = 0; m_age = 0; m_run = 0;
    end else begin
      m_run = (tok >= 0) ? m_run + 1 : 0;
      m_age++;
      if (m_age == SEARCH_TIMEOUT) begin m_slip_left = SLIP_WAIT; e_slip = 1'b1; end
    end
    e_lock = m_locked;
    if (m_locked) begin
      if (tok >= 0) begin e_de = 1'b0; e_data = 8'h00; e_c = tok[1:0]; end
      else begin e_de = 1'b1; e_data = tmds_byte(m_sym); end
    end else begin
      e_de = 1'b0; e_data = 8'h00; e_c = 2'b00;
    end
    m_sym = sym;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] dut_outs();
    return {2'b00, bus.obitslip, bus.olocked, bus.olosspulse, bus.oDE, bus.oc1, bus.oc0, bus.odata};
  endfunction

  initial forever begin
    @(posedge clk);
    model_step(rst, bus.isymbol);
  end

  initial forever begin
    @(negedge clk);
    if (m_valid)
      check("model", dut_outs(), {2'b00, e_slip, e_lock, e_loss, e_de, e_c, e_data});
  end

  task automatic tick(input logic [9:0] s);
    bus.isymbol = s;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(10'h000);
    tick(10'h000);
    rst = 1'b0;
  endtask

  initial begin
    bus.isymbol = 10'h000;
    do_reset();
    check("reset_outputs", dut_outs(), 16'h0000);

    // Lock on 16 x 0x354, then control/data decode
    repeat (16) tick(10'h354);
    tick(10'h354);
    check("lock_not_yet", 16'(bus.olocked), 16'h0);
    tick(10'h354);
    check("lock_rise", 16'({bus.olocked, bus.oc1, bus.oc0, bus.oDE, bus.obitslip}), 16'b10000);
    tick(10'h2AB);
    tick(10'h100);
    check("ctrl_11", 16'({bus.oc1, bus.oc0, bus.oDE}), 16'b110);
    tick(10'h2FF);
    check("data_100", 16'({bus.oDE, bus.odata, bus.oc1, bus.oc0}), 16'({1'b1, 8'h00, 2'b11}));
    tick(10'h354);
    check("data_2ff", 16'({bus.oDE, bus.odata, bus.oc1, bus.oc0}), 16'({1'b1, 8'hFE, 2'b11}));
    tick(10'h354);
    check("ctrl_00", 16'({bus.oc1, bus.oc0, bus.oDE}), 16'b000);

    // Loss of lock after LOSS_TIMEOUT data symbols
    for (int k = 1; k <= 4097; k++) begin
      tick(10'h100);
      check("loss_pulse", 16'({bus.olosspulse, bus.olocked, bus.obitslip}),
            16'({k == 4097, k < 4097, 1'b0}));
    end
    check("loss_outs", 16'({bus.oDE, bus.odata}), 16'h0000);

    // Reset mid-lock, then a fresh run is required
    do_reset();
    repeat (18) tick(10'h2AB);
    check("relock_pre", 16'({bus.olocked, bus.oc1, bus.oc0}), 16'b111);
    rst = 1'b1;
    tick(10'h2AB);
    check("reset_midlock", dut_outs(), 16'h0000);
    rst = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      tick(10'h2AB);
      check("relock", 16'(bus.olocked), 16'(k >= 18));
    end

    // Interrupted run: 15 tokens, one data, 16 tokens
    do_reset();
    for (int k = 1; k <= 34; k++) begin
      tick((k == 16) ? 10'h100 : 10'h354);
      check("broken_run", 16'(bus.olocked), 16'(k >= 34));
    end

    // Misalignment: bitslip at 2048, settle 8, next at 2048+2056
    do_reset();
    for (int k = 1; k <= 4110; k++) begin
      tick(10'h100);
      check("bitslip", 16'({bus.obitslip, bus.olocked}), 16'({(k == 2048) || (k == 4104), 1'b0}));
    end

    // Run completing exactly at timeout: lock wins
    do_reset();
    for (int k = 1; k <= 2060; k++) begin
      tick((k >= 2031 && k <= 2046) ? 10'h354 : 10'h100);
      check("lock_at_timeout", 16'({bus.obitslip, bus.olocked}), 16'({1'b0, k >= 2048}));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tmds_decoder.md
TMDS_DECODER -- requirements
Module: tmds_decoder

Interface
REQ-001 Parameter CTRL_RUN, default 16: number of consecutive control tokens needed to declare lock.
REQ-002 Parameter SEARCH_TIMEOUT, default 2048: number of SEARCH cycles without lock before a bitslip request.
REQ-003 Parameter SLIP_WAIT, default 8: settle cycles after a bitslip request, during which input is ignored.
REQ-004 Parameter LOSS_TIMEOUT, default 4096: number of LOCKED cycles without any control token before lock is dropped.
REQ-005 inclk  in  1  pixel clock; the block uses this one clock only.
REQ-006 ireset  in  1  reset, synchronous and active-high.
REQ-007 isymbol  in  10  raw TMDS symbol from the deserializer, sampled every cycle; bit 0 is first on the wire.
REQ-008 obitslip  out  1  one-cycle request to the deserializer to shift its word boundary by one bit.
REQ-009 olocked  out  1  high while the FSM is in LOCKED.
REQ-010 odata  out  8  decoded pixel byte.
REQ-011 oc0, oc1  out  1 each  control bits (hSync/vSync on the blue channel).
REQ-012 oDE  out  1  data-enable: high for a decoded data symbol.
REQ-013 olosspulse  out  1  one-cycle pulse when lock is lost.

Function
REQ-014 isymbol shall be registered into sym_q every cycle; all decisions shall use sym_q.
REQ-015 Control tokens shall be: 0x354 -> c1c0=00; 0x0AB -> 01; 0x154 -> 10; 0x2AB -> 11. Any other value is a data symbol.
REQ-016 Data decode shall be:
  - d' = q[9] ? ~q[7:0] : q[7:0];
  - d[0] = d'[0];
  - for i=1..7, d[i] = q[8] ? d'[i]^d'[i-1] : ~(d'[i]^d'[i-1]).
REQ-017 Output latency shall be 2 cycles: a symbol sampled at edge n drives outputs after edge n+1.
REQ-018 While LOCKED:
  - control token: oDE=0, odata=0, oc1/oc0 = token bits;
  - data symbol: oDE=1, odata=decoded byte, oc1/oc0 hold their last values.
REQ-019 While not LOCKED: oDE=0, odata=0, oc0=0, oc1=0.
REQ-020 FSM states shall be SEARCH, SLIP, LOCKED; the state entered on reset is SEARCH.
REQ-021 SEARCH: run counter increments on each token in sym_q and clears on any data symbol; timeout counter increments every cycle.
REQ-022 SEARCH -> LOCKED on the edge after the run counter reaches CTRL_RUN; olocked rises on that edge.
REQ-023 SEARCH -> SLIP when the timeout counter reaches SEARCH_TIMEOUT-1 without lock.
  - obitslip is high for exactly the first SLIP cycle.
REQ-024 SLIP shall last SLIP_WAIT cycles and ignore sym_q, then return to SEARCH with both counters cleared.
REQ-025 If lock and timeout conditions occur in the same cycle, lock shall win and no bitslip is issued.
REQ-026 LOCKED: watchdog counter clears on every control token and increments otherwise.
  - On reaching LOSS_TIMEOUT-1: go to SEARCH, olocked=0, olosspulse high for one cycle, counters cleared.
  - No bitslip is issued on loss of lock.
REQ-027 Counters shall saturate and never wrap: run at CTRL_RUN, timeout at SEARCH_TIMEOUT-1, watchdog at LOSS_TIMEOUT-1.
REQ-028 obitslip shall never be asserted in LOCKED, nor on two consecutive cycles.

Reset
REQ-029 Reset values: every output, sym_q and all counters 0; state SEARCH.
REQ-030 ireset asserted mid-operation (any state) shall zero all outputs on the next edge, including a bitslip or loss pulse in progress.
REQ-031 No bitslip shall be issued until SEARCH_TIMEOUT cycles after reset release.

Verification
REQ-032 Lock: reset, then 16 x 0x354 -> olocked=1 two edges after the 16th sample; oc1oc0=00, oDE=0, no obitslip.
REQ-033 Control and data decode, locked:
  - 0x2AB -> oc1oc0=11, oDE=0 after 2 cycles;
  - 0x100 -> odata=0x00, oDE=1;
  - 0x2FF -> odata=0xFE, oDE=1; oc bits stay 11.
REQ-034 Misalignment: 2048 cycles of 0x100 from reset ->
  - single obitslip pulse at cycle 2048;
  - no pulse for the next 8 cycles;
  - next pulse 2048+8 cycles later if 0x100 continues.
REQ-035 Boundary: 15 tokens, one 0x100, 16 tokens -> lock only after the second run; a run ending exactly at timeout -> lock, no obitslip.
REQ-036 Loss: locked, then 4096 x 0x100 -> olosspulse one cycle, olocked=0, oDE=0, odata=0.
REQ-037 Reset mid-lock: ireset for one cycle -> all outputs 0 next edge; relock needs a fresh run of 16 tokens.
